// File: rtl/picosoc_gpio.sv
// Memory-mapped GPIO port for the PicoSoC iomem bus: output data/enable, synchronised
// input readback, atomic set/clear and per-bit edge interrupts.
module picosoc_gpio #(
    parameter int unsigned WIDTH       = 8,
    parameter logic [7:0]  BASE_ADDR   = 8'h03,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             iomem_valid,
    output logic             iomem_ready,
    input  logic [3:0]       iomem_wstrb,
    input  logic [31:0]      iomem_addr,
    input  logic [31:0]      iomem_wdata,
    output logic [31:0]      iomem_rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam logic [2:0] REG_OUT     = 3'd0;
    localparam logic [2:0] REG_OE      = 3'd1;
    localparam logic [2:0] REG_IN      = 3'd2;
    localparam logic [2:0] REG_RISE_EN = 3'd3;
    localparam logic [2:0] REG_FALL_EN = 3'd4;
    localparam logic [2:0] REG_PEND    = 3'd5;
    localparam logic [2:0] REG_OUT_SET = 3'd6;
    localparam logic [2:0] REG_OUT_CLR = 3'd7;

    logic                                 ready_q;
    logic [31:0]                          rdata_q;
    logic [31:0]                          rdata_d;
    logic [WIDTH-1:0]                     out_q, out_d;
    logic [WIDTH-1:0]                     oe_q, oe_d;
    logic [WIDTH-1:0]                     rise_en_q, rise_en_d;
    logic [WIDTH-1:0]                     fall_en_q, fall_en_d;
    logic [WIDTH-1:0]                     pend_q, pend_d;
    logic [SYNC_STAGES-1:0][WIDTH-1:0]    sync_q;
    logic [WIDTH-1:0]                     in_s;
    logic [WIDTH-1:0]                     in_d_q;

    logic                                 sel_c;
    logic                                 wr_c;
    logic [2:0]                           idx_c;
    logic [WIDTH-1:0]                     wr_mask_c;
    logic [WIDTH-1:0]                     wr_data_c;
    logic [WIDTH-1:0]                     rd_val_c;
    logic [WIDTH-1:0]                     rise_c;
    logic [WIDTH-1:0]                     fall_c;
    logic [WIDTH-1:0]                     pend_clr_c;
    logic                                 unused_c;

    // Address bits outside the top byte and the register index alias the window.
    assign unused_c = ^{iomem_addr[23:5], iomem_addr[1:0], iomem_wdata};

    assign in_s   = sync_q[SYNC_STAGES-1];
    assign rise_c = in_s & ~in_d_q;
    assign fall_c = ~in_s & in_d_q;

    // Bus decode and byte-lane masking, trimmed to the implemented pin count.
    always_comb begin
        sel_c     = iomem_valid && !ready_q && (iomem_addr[31:24] == BASE_ADDR);
        wr_c      = |iomem_wstrb;
        idx_c     = iomem_addr[4:2];
        wr_mask_c = WIDTH'({{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                            {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}});
        wr_data_c = WIDTH'(iomem_wdata) & wr_mask_c;
    end

    // Read mux samples state before any same-cycle write.
    always_comb begin
        rd_val_c = '0;
        case (idx_c)
            REG_OUT, REG_OUT_SET, REG_OUT_CLR: rd_val_c = out_q;
            REG_OE:                            rd_val_c = oe_q;
            REG_IN:                            rd_val_c = in_s;
            REG_RISE_EN:                       rd_val_c = rise_en_q;
            REG_FALL_EN:                       rd_val_c = fall_en_q;
            REG_PEND:                          rd_val_c = pend_q;
            default:                           rd_val_c = '0;
        endcase
        rdata_d = sel_c ? 32'(rd_val_c) : 32'd0;
    end

    // Register write decode; a pending edge always beats a same-cycle W1C.
    always_comb begin
        out_d      = out_q;
        oe_d       = oe_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        pend_clr_c = '0;
        if (sel_c && wr_c) begin
            case (idx_c)
                REG_OUT:     out_d      = (out_q & ~wr_mask_c) | wr_data_c;
                REG_OE:      oe_d       = (oe_q & ~wr_mask_c) | wr_data_c;
                REG_RISE_EN: rise_en_d  = (rise_en_q & ~wr_mask_c) | wr_data_c;
                REG_FALL_EN: fall_en_d  = (fall_en_q & ~wr_mask_c) | wr_data_c;
                REG_PEND:    pend_clr_c = wr_data_c;
                REG_OUT_SET: out_d      = out_q | wr_data_c;
                REG_OUT_CLR: out_d      = out_q & ~wr_data_c;
                default:     ;
            endcase
        end
        pend_d = (pend_q & ~pend_clr_c) | (rise_c & rise_en_q) | (fall_c & fall_en_q);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            out_q     <= '0;
            oe_q      <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            pend_q    <= '0;
            sync_q    <= '0;
            in_d_q    <= '0;
        end else begin
            ready_q   <= sel_c;
            rdata_q   <= rdata_d;
            out_q     <= out_d;
            oe_q      <= oe_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            pend_q    <= pend_d;
            sync_q    <= {sync_q[SYNC_STAGES-2:0], gpio_in};
            in_d_q    <= in_s;
        end
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign gpio_out    = out_q;
    assign gpio_oe     = oe_q;
    assign irq         = |pend_q;

endmodule

// File: tb/tb_picosoc_gpio.sv
// Bench for picosoc_gpio: directed literal checks plus randomized traffic compared
// every cycle against a register-level model of the port.
module tb_picosoc_gpio;

    localparam int unsigned W     = 8;
    localparam int unsigned SS    = 2;
    localparam logic [7:0]  BASE  = 8'h03;
    localparam logic [31:0] WMASK = 32'h0000_00FF;

    localparam logic [31:0] A_OUT  = 32'h0300_0000;
    localparam logic [31:0] A_OE   = 32'h0300_0004;
    localparam logic [31:0] A_RISE = 32'h0300_000C;
    localparam logic [31:0] A_FALL = 32'h0300_0010;
    localparam logic [31:0] A_PEND = 32'h0300_0014;
    localparam logic [31:0] A_SET  = 32'h0300_0018;
    localparam logic [31:0] A_CLR  = 32'h0300_001C;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          iomem_valid = 1'b0;
    logic          iomem_ready;
    logic [3:0]    iomem_wstrb = 4'h0;
    logic [31:0]   iomem_addr = 32'h0;
    logic [31:0]   iomem_wdata = 32'h0;
    logic [31:0]   iomem_rdata;
    logic [W-1:0]  gpio_in = '0;
    logic [W-1:0]  gpio_out;
    logic [W-1:0]  gpio_oe;
    logic          irq;

    int n_chk  = 0;
    int n_pass = 0;

    picosoc_gpio #(.WIDTH(W), .BASE_ADDR(BASE), .SYNC_STAGES(SS)) dut (
        .clk(clk), .resetn(resetn),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
        .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Model: register values as plain words, pin history as a queue (newest first).
    logic [31:0] m_out, m_oe, m_ren, m_fen, m_pend, m_rdata;
    logic        m_ready;
    logic [31:0] hist[$];

    task automatic m_reset();
        m_out = 0; m_oe = 0; m_ren = 0; m_fen = 0; m_pend = 0;
        m_rdata = 0; m_ready = 1'b0;
        hist = {};
        for (int i = 0; i <= SS; i++) hist.push_back(32'h0);
    endtask

    // Advance the model to the state after the coming rising edge.
    task automatic m_step();
        logic [31:0] ins, ind, evt, rv, mask, d, clr;
        logic        sel;
        if (!resetn) begin
            m_reset();
            return;
        end
        ins = hist[SS-1];
        ind = hist[SS];
        evt = ((ins & ~ind) & m_ren) | ((~ins & ind) & m_fen);
        sel = iomem_valid && !m_ready && (iomem_addr[31:24] == BASE);
        case (iomem_addr[4:2])
            3'd1:    rv = m_oe;
            3'd2:    rv = ins;
            3'd3:    rv = m_ren;
            3'd4:    rv = m_fen;
            3'd5:    rv = m_pend;
            default: rv = m_out;
        endcase
        clr = 0;
        if (sel && iomem_wstrb != 4'h0) begin
            mask = 0;
            for (int b = 0; b < 4; b++)
                if (iomem_wstrb[b]) mask = mask | (32'h0000_00FF << (8 * b));
            mask = mask & WMASK;
            d = iomem_wdata & mask;
            case (iomem_addr[4:2])
                3'd0: m_out = (m_out & ~mask) | d;
                3'd1: m_oe  = (m_oe & ~mask) | d;
                3'd3: m_ren = (m_ren & ~mask) | d;
                3'd4: m_fen = (m_fen & ~mask) | d;
                3'd5: clr   = d;
                3'd6: m_out = m_out | d;
                3'd7: m_out = m_out & ~d;
                default: ;
            endcase
        end
        m_pend = (m_pend & ~clr) | evt;
        hist.push_front(32'(gpio_in));
        void'(hist.pop_back());
        m_ready = sel;
        m_rdata = rv;
    endtask

    // Every falling edge: compare DUT against the model, then advance the model.
    initial begin
        m_reset();
        forever begin
            @(negedge clk);
            if (!resetn) m_reset();
            check("gpio_out", 32'(gpio_out), m_out);
            check("gpio_oe", 32'(gpio_oe), m_oe);
            check("irq", 32'(irq), 32'(m_pend != 0));
            check("ready", 32'(iomem_ready), 32'(m_ready));
            if (m_ready) check("rdata", iomem_rdata, m_rdata);
            m_step();
        end
    end

    task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] wd,
                       input bit expect_resp, output logic [31:0] rd);
        bit ok;
        rd = 32'h0;
        ok = 1'b0;
        @(posedge clk);
        #2;
        iomem_valid = 1'b1;
        iomem_addr  = a;
        iomem_wstrb = s;
        iomem_wdata = wd;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (iomem_ready) begin
                ok = 1'b1;
                rd = iomem_rdata;
                break;
            end
            if (!expect_resp) check("no_resp", 32'(iomem_ready), 32'h0);
        end
        if (expect_resp) check("bus_ack", 32'(ok), 32'h1);
        @(posedge clk);
        #2;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        @(negedge clk);
        check("ready_pulse", 32'(iomem_ready), 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  top;
        logic [3:0]  s;
        logic [31:0] a;
        int unsigned idle;

        repeat (3) @(posedge clk);
        #2 resetn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            bus(32'h0300_0000 | 32'(i << 2), 4'h0, 32'h0, 1'b1, rd);
            check($sformatf("reset_rd%0d", i), rd, 32'h0);
        end
        check("reset_oe", 32'(gpio_oe), 32'h0);
        check("reset_irq", 32'(irq), 32'h0);

        bus(A_OUT, 4'b0001, 32'h0000_00A5, 1'b1, rd);
        bus(A_OUT, 4'b1110, 32'hFFFF_FF00, 1'b1, rd);
        bus(A_OUT, 4'b0000, 32'h0, 1'b1, rd);
        check("byte_lane", rd, 32'h0000_00A5);

        bus(A_OUT, 4'hF, 32'h0000_000F, 1'b1, rd);
        bus(A_SET, 4'hF, 32'h0000_0030, 1'b1, rd);
        check("out_set", 32'(gpio_out), 32'h0000_003F);
        bus(A_CLR, 4'hF, 32'h0000_0005, 1'b1, rd);
        check("out_clr", 32'(gpio_out), 32'h0000_003A);

        bus(A_RISE, 4'hF, 32'h0000_0001, 1'b1, rd);
        @(posedge clk);
        #2 gpio_in[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("irq_early", 32'(irq), 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("irq_rise", 32'(irq), 32'h1);
        bus(A_PEND, 4'h0, 32'h0, 1'b1, rd);
        check("pend_rise", rd, 32'h0000_0001);
        bus(A_PEND, 4'hF, 32'h0000_0001, 1'b1, rd);
        check("irq_w1c", 32'(irq), 32'h0);

        bus(A_FALL, 4'hF, 32'h0000_0004, 1'b1, rd);
        @(posedge clk);
        #2 gpio_in[2] = 1'b1;
        repeat (4) @(posedge clk);
        #2 gpio_in[2] = 1'b0;
        @(posedge clk);
        bus(A_PEND, 4'hF, 32'h0000_0004, 1'b1, rd);
        check("set_beats_clear_irq", 32'(irq), 32'h1);
        bus(A_PEND, 4'h0, 32'h0, 1'b1, rd);
        check("set_beats_clear", rd, 32'h0000_0004);

        bus(32'h0200_0004, 4'hF, 32'hFFFF_FFFF, 1'b0, rd);
        check("decode_oe", 32'(gpio_oe), 32'h0);
        bus(A_OE, 4'hF, 32'hFFFF_FFFF, 1'b1, rd);
        bus(A_OE, 4'h0, 32'h0, 1'b1, rd);
        check("oe_width", rd, 32'h0000_00FF);
        bus(32'h03AB_CDE5, 4'h0, 32'h0, 1'b1, rd);
        check("alias", rd, 32'h0000_00FF);

        for (int it = 0; it < 500; it++) begin
            if (it == 250) begin
                @(posedge clk);
                #2 resetn = 1'b0;
                repeat (2) @(posedge clk);
                #2 resetn = 1'b1;
            end
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk);
                #2 gpio_in = W'($urandom);
            end
            idle = $urandom_range(0, 2);
            repeat (idle) @(posedge clk);
            top = ($urandom_range(0, 7) == 0) ? 8'h02 : BASE;
            s   = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            a   = {top, 19'($urandom), 3'($urandom_range(0, 7)), 2'($urandom)};
            bus(a, s, $urandom, top == BASE, rd);
        end

        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/picosoc_gpio.md
# picosoc_gpio

Parametrised memory-mapped GPIO peripheral for the PicoSoC `iomem` bus. It replaces the fixed 32-bit write-only LED register in board top levels with a general port. The port provides per-bit output enable, a synchronised input readback, atomic set/clear writes, and per-bit rising/falling-edge interrupts. It sits beside other `iomem` slaves in the board top level; its `irq` output feeds one of the SoC `irq_5..irq_7` inputs.

## Interface
Clock and reset: one clock; reset is asynchronous and active-low.

Parameters:
- `WIDTH`, default 8: number of GPIO pins, 1..32.
- `BASE_ADDR`, default 8'h03: value of `iomem_addr[31:24]` that selects this block.
- `SYNC_STAGES`, default 2: input synchroniser depth, minimum 2.

Ports:
- `clk`  in  1  system clock.
- `resetn`  in  1  asynchronous active-low reset.
- `iomem_valid`  in  1  bus request.
- `iomem_ready`  out  1  one-cycle acknowledge.
- `iomem_wstrb`  in  4  byte write strobes; 0 means read.
- `iomem_addr`  in  32  byte address.
- `iomem_wdata`  in  32  write data.
- `iomem_rdata`  out  32  read data, valid while `iomem_ready`=1.
- `gpio_in`  in  WIDTH  asynchronous pin inputs.
- `gpio_out`  out  WIDTH  output data register.
- `gpio_oe`  out  WIDTH  output enable; 1 = drive.
- `irq`  out  1  OR of all pending bits.

## Operation
- Select condition: `iomem_valid && !iomem_ready && iomem_addr[31:24]==BASE_ADDR`. Register index is `iomem_addr[4:2]`. Bits [23:5] and [1:0] are ignored, so the block aliases across its window.
- Register map (byte offsets):
  - 0x00 OUT: RW.
  - 0x04 OE: RW.
  - 0x08 IN: RO, returns the synchronised inputs.
  - 0x0C RISE_EN: RW.
  - 0x10 FALL_EN: RW.
  - 0x14 PEND: read returns pending bits; writing 1 clears a bit (W1C).
  - 0x18 OUT_SET: writing 1 sets the OUT bit; read returns OUT.
  - 0x1C OUT_CLR: writing 1 clears the OUT bit; read returns OUT.
- Byte lanes: a write affects only bytes whose `iomem_wstrb` bit is set. Any access with nonzero `iomem_wstrb` is a write. Writes to RO IN are acknowledged and discarded.
- Bits at or above WIDTH read as 0 and ignore writes.
- Synchroniser: `gpio_in` passes through SYNC_STAGES flops to give `in_s`. One further flop gives `in_d`.
  - rise = `in_s & ~in_d`, fall = `~in_s & in_d`.
  - PEND bit sets when (rise & RISE_EN) | (fall & FALL_EN).
- PEND rules:
  - Enables act only on edges detected while set. Enabling does not retro-fire.
  - Clearing an enable does not clear PEND.
  - If an edge sets a bit in the same cycle a W1C clears it, the set wins and the bit stays 1.
- `irq` = |PEND. It is combinational from flops only, with no bus-path logic.
- Addresses with a non-matching top byte get no response: `iomem_ready` stays 0 and no state changes.

## Timing
- Reset (`resetn`=0, asynchronous) clears all of the following to 0: `iomem_ready`, `iomem_rdata`, OUT, OE, RISE_EN, FALL_EN, PEND, synchroniser and `in_d` flops. Consequences: `gpio_out`=0, `gpio_oe`=0, `irq`=0.
- An input already high at reset release produces a rise edge SYNC_STAGES+1 cycles later. It sets PEND only if RISE_EN was written by then.
- Bus latency: select seen at edge N gives `iomem_ready`=1 and `iomem_rdata` valid during cycle N+1. `iomem_ready` returns to 0 at edge N+1 even if `iomem_valid` stays high. Back-to-back accesses therefore take 2 cycles each.
- Write effects (OUT, OE, enables, PEND clear) are visible on outputs from cycle N+1.
- Read data is the register value before any same-cycle write, which is read-modify-safe for W1C.
- Pin to IN readback: a `gpio_in` change before edge K is reflected in `in_s` after edge K+SYNC_STAGES-1.
- PEND sets, and `irq` rises, one edge after `in_s` changes. With SYNC_STAGES=2, that is 3 edges after the pin change.
- Assertion of `resetn` mid-transaction aborts it. The master retries after reset.

## Test plan
- Reset values: after reset, read all 8 offsets → all return 0; `gpio_oe`=0; `irq`=0.
- Byte-lane write: write 0xA5 to OUT with wstrb=4'b0001 (WIDTH=8); then wdata=0xFFFF_FF00 with wstrb=4'b1110 → OUT stays 0xA5 and `iomem_ready` pulses exactly one cycle per access.
- Set/clear atomicity: OUT=0x0F; write 0x30 to OUT_SET → `gpio_out`=0x3F; write 0x05 to OUT_CLR → `gpio_out`=0x3A.
- Input sync and edge irq: RISE_EN=0x01 and `gpio_in[0]` 0→1 → PEND=0x01 and `irq`=1 exactly 3 cycles later (SYNC_STAGES=2). A W1C of 0x01 to PEND → `irq`=0 next cycle.
- Set-beats-clear: a falling edge on bit 2 with FALL_EN=0x04 lands in the same cycle as a W1C of 0x04 → PEND[2] remains 1.
- Decode and width: an access with `iomem_addr[31:24]`=0x02 → no `iomem_ready` within 4 cycles. Write 0xFFFF_FFFF to OE with WIDTH=8 → reads back 0x0000_00FF.
